// File: rtl/cdc_fifo_wr_packetizer.sv
// Store-and-forward packetizer on the write side of an async FIFO: it buffers one packet,
// then writes a length header followed by the payload beats in arrival order.
module cdc_fifo_wr_packetizer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 16
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  wr_full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [15:0]           pkt_count,
    output logic                  err_trunc,
    output logic [1:0]            dbg_state
);

    // Handshakes: an input beat transfers on a rising edge with in_valid & in_ready;
    // a FIFO word is written on every rising edge with wr_en=1, which never rises while wr_full=1.

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);

    typedef enum logic [1:0] {FILL, DROP, HDR, PAY} state_t;

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, idx, cnt_m1;
    logic [DATA_WIDTH-1:0] pkt_buf [MAX_LEN];
    logic store, trunc_set, pay_done;

    // cnt holds the stored length; it saturates at MAX_LEN while a long packet drains in DROP
    assign cnt_m1    = cnt - CNT_W'(1);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        wr_data   = pkt_buf[idx[IDX_W-1:0]];
        store     = 1'b0;
        trunc_set = 1'b0;
        pay_done  = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    store = 1'b1;
                    if (in_last) begin
                        state_nxt = HDR;
                    end else if (cnt == CNT_W'(MAX_LEN - 1)) begin
                        state_nxt = DROP;
                        trunc_set = 1'b1;
                    end
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nxt = HDR;
            end
            HDR: begin
                wr_data = DATA_WIDTH'(cnt_m1);
                wr_en   = !wr_full;
                if (!wr_full) state_nxt = PAY;
            end
            PAY: begin
                wr_en = !wr_full;
                if (!wr_full && idx == cnt_m1) begin
                    pay_done  = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            idx       <= '0;
            pkt_count <= '0;
            err_trunc <= 1'b0;
        end else begin
            state <= state_nxt;
            if (store) cnt <= cnt + CNT_W'(1);
            if (state == HDR && wr_en) idx <= '0;
            if (state == PAY && wr_en) idx <= idx + CNT_W'(1);
            if (pay_done) begin
                cnt       <= '0;
                idx       <= '0;
                pkt_count <= pkt_count + 16'd1;
            end
            if (trunc_set) err_trunc <= 1'b1;
        end
    end

    // Payload storage carries no reset; only indices gate what is read back
    always_ff @(posedge wr_clk) begin
        if (store) pkt_buf[cnt[IDX_W-1:0]] <= in_data;
    end

endmodule

// File: tb/tb_cdc_fifo_wr_packetizer.sv
// Bench for cdc_fifo_wr_packetizer: table-driven packets, hand-written corner sequences and
// randomized packets with FIFO-full stalls, all checked against a packet-level reference model.
module tb_cdc_fifo_wr_packetizer;
    localparam int DW = 8;
    localparam int ML = 16;

    logic          wr_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          wr_full = 1'b0;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [15:0]   pkt_count;
    logic          err_trunc;
    logic [1:0]    dbg_state;

    cdc_fifo_wr_packetizer #(.DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
        .wr_clk(wr_clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .wr_full(wr_full), .wr_en(wr_en),
        .wr_data(wr_data), .pkt_count(pkt_count), .err_trunc(err_trunc), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 wr_clk = ~wr_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit full_rand = 0;
    bit full_force = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            got_cyc[$];
    logic [DW-1:0] pkt_q[$];
    int   model_pkts = 0;
    logic model_trunc = 1'b0;

    always @(posedge wr_clk) cyc++;

    always @(posedge wr_clk) begin
        #1;
        wr_full = full_force | (full_rand ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // FIFO-side monitor, sampled mid-cycle
    always @(negedge wr_clk) begin
        if (rst_n) begin
            if (wr_full) begin
                n_cmp++;
                if (wr_en) begin
                    n_err++;
                    $display("FAIL wr_en_while_full: wr_en=%0b required 0 at cycle %0d", wr_en, cyc);
                end
            end
            if (wr_en) begin
                got_q.push_back(wr_data);
                got_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // reference model: header = min(len,ML)-1, then the first min(len,ML) beats
    task automatic model_pkt();
        int n, k;
        n = pkt_q.size();
        k = (n > ML) ? ML : n;
        exp_q.push_back(DW'(k - 1));
        for (int i = 0; i < k; i++) exp_q.push_back(pkt_q[i]);
        if (n > ML) model_trunc = 1'b1;
        model_pkts++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (2) @(negedge wr_clk);
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        model_pkts = 0;
        model_trunc = 1'b0;
        rst_n = 1'b1;
    endtask

    // driver: sends pkt_q, optionally with idle gaps between beats
    task automatic send_pkt(input int gap_max);
        int n;
        n = pkt_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge wr_clk);
            in_valid = 1'b0;
            in_last = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge wr_clk);
            in_valid = 1'b1;
            in_data = pkt_q[i];
            in_last = (i == n - 1);
            if (!in_ready) begin
                n_cmp++;
                n_err++;
                $display("FAIL in_ready_fill: got 0 required 1 at beat %0d", i);
            end
        end
        @(negedge wr_clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // scoreboard: wait for the packet to complete, then compare every FIFO word
    task automatic drain(input bit back_to_back, output logic [DW-1:0] first_word);
        int t;
        t = 0;
        while (pkt_count != 16'(model_pkts) && t < 2000) begin
            @(negedge wr_clk);
            t++;
        end
        if (t >= 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: pkt_count=%0d required %0d", pkt_count, model_pkts);
        end
        repeat (2) @(negedge wr_clk);
        first_word = (got_q.size() > 0) ? got_q[0] : 'x;
        chk("word_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("word[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
        if (back_to_back)
            for (int i = 1; i < got_cyc.size(); i++)
                chk($sformatf("gapless[%0d]", i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd1);
        chk("pkt_count", 32'(pkt_count), 32'(16'(model_pkts)));
        chk("err_trunc", 32'(err_trunc), 32'(model_trunc));
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    typedef struct {
        int            len;
        logic [DW-1:0] base;
        logic [DW-1:0] step;
        logic [DW-1:0] exp_hdr;
        logic [15:0]   exp_cnt;
        logic          exp_trunc;
    } vec_t;

    vec_t vecs[6];
    logic [DW-1:0] fw;

    initial begin
        vecs[0] = '{3,  8'h11, 8'h11, 8'h02, 16'd1, 1'b0};
        vecs[1] = '{1,  8'hA5, 8'h00, 8'h00, 16'd2, 1'b0};
        vecs[2] = '{16, 8'h40, 8'h01, 8'h0F, 16'd3, 1'b0};
        vecs[3] = '{2,  8'h01, 8'h01, 8'h01, 16'd4, 1'b0};
        vecs[4] = '{20, 8'h80, 8'h01, 8'h0F, 16'd5, 1'b1};
        vecs[5] = '{4,  8'hC0, 8'h03, 8'h03, 16'd6, 1'b1};

        do_reset();
        @(negedge wr_clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_err_trunc", 32'(err_trunc), 32'd0);

        // table-driven packets, FIFO never full
        for (int v = 0; v < 6; v++) begin
            pkt_q.delete();
            for (int i = 0; i < vecs[v].len; i++) pkt_q.push_back(vecs[v].base + DW'(i) * vecs[v].step);
            model_pkt();
            send_pkt(0);
            drain(1'b1, fw);
            chk($sformatf("vec%0d_hdr", v), 32'(fw), 32'(vecs[v].exp_hdr));
            chk($sformatf("vec%0d_cnt", v), 32'(pkt_count), 32'(vecs[v].exp_cnt));
            chk($sformatf("vec%0d_trunc", v), 32'(err_trunc), 32'(vecs[v].exp_trunc));
        end

        // long full stall while the header is pending: nothing may be written
        pkt_q.delete();
        pkt_q = '{8'h5A, 8'h6B};
        model_pkt();
        full_force = 1;
        send_pkt(0);
        repeat (10) @(negedge wr_clk);
        chk("stall_no_writes", 32'(got_q.size()), 32'd0);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        full_force = 0;
        drain(1'b0, fw);

        // randomized packets with random FIFO-full stalls and input gaps
        full_rand = 1;
        for (int p = 0; p < 30; p++) begin
            pkt_q.delete();
            repeat ($urandom_range(1, 20)) pkt_q.push_back(DW'($urandom));
            model_pkt();
            send_pkt(2);
            drain(1'b0, fw);
        end
        full_rand = 0;
        @(negedge wr_clk);

        // reset during PAY after header plus two of five payload words
        pkt_q.delete();
        pkt_q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
        send_pkt(0);
        begin
            int t;
            t = 0;
            while (got_q.size() < 3 && t < 50) begin
                @(negedge wr_clk);
                t++;
            end
            chk("pre_reset_words", 32'(got_q.size()), 32'd3);
        end
        @(posedge wr_clk);
        #1 rst_n = 1'b0;
        #1 chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_pkt_count", 32'(pkt_count), 32'd0);
        chk("reset_err_trunc", 32'(err_trunc), 32'd0);
        do_reset();
        pkt_q.delete();
        pkt_q = '{8'h01, 8'h02};
        model_pkt();
        send_pkt(0);
        drain(1'b1, fw);
        chk("post_reset_hdr", 32'(fw), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
